// File: rtl/wb_write_arbiter.sv
// -----------------------------------------------------------------------------
// wb_write_arbiter
//
// Shares the single register-file write port between the in-order pipeline's
// write-back stage and a long-latency execution unit (multiply/divide) whose
// results complete out of band. Long-latency results are parked in a small
// FIFO and drained into write-back slots that the pipeline leaves idle. If the
// FIFO head waits too long, a one-cycle stall is forced so the head can be
// written and the queue keeps making forward progress.
//
// Parameters
//   DEPTH        number of FIFO entries (power of two, >= 2)
//   STARVE_LIMIT cycles the FIFO head may wait before a stall is forced (1..15)
//   XLEN         data width
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rstn         asynchronous active-low reset
//   wb_we        WB stage requests a register write this cycle
//   wb_rd_addr   WB destination register
//   wb_rd_data   WB write data
//   lu_valid     long-latency unit presents a result
//   lu_rd_addr   long-latency result destination register
//   lu_rd_data   long-latency result data
//   lu_ready     FIFO can accept a result (registered state only)
//   stall_req    pipeline must hold WB this cycle and re-present it next cycle
//   rf_we        register-file write enable (combinational)
//   rf_waddr     register-file write address (combinational)
//   rf_wdata     register-file write data (combinational)
//   pending_cnt  number of occupied FIFO entries
// -----------------------------------------------------------------------------
module wb_write_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4,
    parameter int XLEN         = 64
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     wb_we,
    input  logic [4:0]               wb_rd_addr,
    input  logic [XLEN-1:0]          wb_rd_data,
    input  logic                     lu_valid,
    input  logic [4:0]               lu_rd_addr,
    input  logic [XLEN-1:0]          lu_rd_data,
    output logic                     lu_ready,
    output logic                     stall_req,
    output logic                     rf_we,
    output logic [4:0]               rf_waddr,
    output logic [XLEN-1:0]          rf_wdata,
    output logic [$clog2(DEPTH):0]   pending_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);
    localparam logic [3:0]       STARVE_MAX = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        GRANT_IDLE,
        GRANT_WB,
        GRANT_DRAIN,
        GRANT_FORCE
    } grant_t;

    // FIFO storage holds data only; it needs no reset because occupancy is
    // tracked by the control registers below.
    logic [4:0]      fifo_addr [DEPTH];
    logic [XLEN-1:0] fifo_data [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [3:0]       starve_cnt;

    grant_t grant;
    logic   push;
    logic   pop;
    logic   fifo_empty;

    // Saturating increment for the starvation counter.
    function automatic logic [3:0] starve_inc(input logic [3:0] cnt);
        return (cnt >= STARVE_MAX) ? cnt : cnt + 4'd1;
    endfunction

    assign fifo_empty = (count == '0);

    // Both handshake and force decisions come from registered state only, so
    // neither output has a combinational path from the wb_* / lu_* inputs.
    assign lu_ready  = (count != FULL_CNT);
    assign stall_req = (starve_cnt == STARVE_MAX) && !fifo_empty;

    // Results addressed to x0 complete the handshake but are never queued.
    assign push = lu_valid && lu_ready && (lu_rd_addr != 5'd0);

    always_comb begin
        grant = GRANT_IDLE;
        if (stall_req) begin
            grant = GRANT_FORCE;
        end else if (wb_we && (wb_rd_addr != 5'd0)) begin
            grant = GRANT_WB;
        end else if (!fifo_empty) begin
            grant = GRANT_DRAIN;
        end
    end

    assign pop = (grant == GRANT_FORCE) || (grant == GRANT_DRAIN);

    // The write enable is gated by rstn so nothing reaches the register file
    // while reset is asserted, even before the flops have settled.
    assign rf_we    = rstn && (grant != GRANT_IDLE);
    assign rf_waddr = pop ? fifo_addr[rd_ptr] : wb_rd_addr;
    assign rf_wdata = pop ? fifo_data[rd_ptr] : wb_rd_data;

    assign pending_cnt = count;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= lu_rd_addr;
            fifo_data[wr_ptr] <= lu_rd_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
        end else begin
            // DEPTH is a power of two, so natural pointer overflow wraps.
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end

            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            // Restarting at 0 after every pop keeps each forced stall to a
            // single cycle and gives the next head a full waiting window.
            if (pop || fifo_empty) begin
                starve_cnt <= '0;
            end else begin
                starve_cnt <= starve_inc(starve_cnt);
            end
        end
    end

endmodule

// File: tb/tb_wb_write_arbiter.sv
module tb_wb_write_arbiter;

    localparam int DEPTH        = 2;
    localparam int STARVE_LIMIT = 4;
    localparam int XLEN         = 64;

    logic            clk;
    logic            rstn;
    logic            wb_we;
    logic [4:0]      wb_rd_addr;
    logic [XLEN-1:0] wb_rd_data;
    logic            lu_valid;
    logic [4:0]      lu_rd_addr;
    logic [XLEN-1:0] lu_rd_data;
    logic            lu_ready;
    logic            stall_req;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic [1:0]      pending_cnt;

    int checks = 0;
    int passes = 0;

    // Starvation scenario table: WB data presented, expected stall, address, data.
    logic [XLEN-1:0] st_wb_data [6];
    logic            st_stall   [6];
    logic [4:0]      st_addr    [6];
    logic [XLEN-1:0] st_data    [6];

    wb_write_arbiter #(
        .DEPTH       (DEPTH),
        .STARVE_LIMIT(STARVE_LIMIT),
        .XLEN        (XLEN)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .wb_we      (wb_we),
        .wb_rd_addr (wb_rd_addr),
        .wb_rd_data (wb_rd_data),
        .lu_valid   (lu_valid),
        .lu_rd_addr (lu_rd_addr),
        .lu_rd_data (lu_rd_data),
        .lu_ready   (lu_ready),
        .stall_req  (stall_req),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .pending_cnt(pending_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_we      = 1'b0;
        wb_rd_addr = 5'd0;
        wb_rd_data = '0;
        lu_valid   = 1'b0;
        lu_rd_addr = 5'd0;
        lu_rd_data = '0;
    endtask

    task automatic test_reset();
        rstn       = 1'b0;
        wb_we      = 1'b1;
        wb_rd_addr = 5'd4;
        wb_rd_data = 64'h44;
        lu_valid   = 1'b1;
        lu_rd_addr = 5'd6;
        lu_rd_data = 64'h66;
        #3;
        checks++; if (rf_we !== 1'b0) $display("FAIL reset_rf_we: got %b want 0", rf_we); else passes++;
        checks++; if (lu_ready !== 1'b1) $display("FAIL reset_lu_ready: got %b want 1", lu_ready); else passes++;
        checks++; if (stall_req !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall_req); else passes++;
        checks++; if (pending_cnt !== 2'd0) $display("FAIL reset_pending: got %0d want 0", pending_cnt); else passes++;
        step();
        step();
        checks++; if (pending_cnt !== 2'd0) $display("FAIL reset_held_pending: got %0d want 0", pending_cnt); else passes++;
        checks++; if (rf_we !== 1'b0) $display("FAIL reset_held_rf_we: got %b want 0", rf_we); else passes++;
        idle_inputs();
        rstn = 1'b1;
        step();
    endtask

    task automatic test_lone_result();
        lu_valid   = 1'b1;
        lu_rd_addr = 5'd5;
        lu_rd_data = 64'hDEAD;
        #2;
        checks++; if (pending_cnt !== 2'd0) $display("FAIL lone_c0_pending: got %0d want 0", pending_cnt); else passes++;
        checks++; if (rf_we !== 1'b0) $display("FAIL lone_c0_bypass: got rf_we %b want 0", rf_we); else passes++;
        step();
        idle_inputs();
        #2;
        checks++; if (pending_cnt !== 2'd1) $display("FAIL lone_c1_pending: got %0d want 1", pending_cnt); else passes++;
        checks++; if (rf_we !== 1'b1) $display("FAIL lone_c1_rf_we: got %b want 1", rf_we); else passes++;
        checks++; if (rf_waddr !== 5'd5) $display("FAIL lone_c1_addr: got %0d want 5", rf_waddr); else passes++;
        checks++; if (rf_wdata !== 64'hDEAD) $display("FAIL lone_c1_data: got %h want dead", rf_wdata); else passes++;
        step();
        #2;
        checks++; if (pending_cnt !== 2'd0) $display("FAIL lone_c2_pending: got %0d want 0", pending_cnt); else passes++;
        checks++; if (rf_we !== 1'b0) $display("FAIL lone_c2_rf_we: got %b want 0", rf_we); else passes++;
        step();
    endtask

    task automatic test_collision();
        wb_we      = 1'b1;
        wb_rd_addr = 5'd3;
        wb_rd_data = 64'h11;
        lu_valid   = 1'b1;
        lu_rd_addr = 5'd7;
        lu_rd_data = 64'h22;
        #2;
        checks++; if (rf_we !== 1'b1) $display("FAIL coll_c0_rf_we: got %b want 1", rf_we); else passes++;
        checks++; if (rf_waddr !== 5'd3) $display("FAIL coll_c0_addr: got %0d want 3", rf_waddr); else passes++;
        checks++; if (rf_wdata !== 64'h11) $display("FAIL coll_c0_data: got %h want 11", rf_wdata); else passes++;
        step();
        idle_inputs();
        #2;
        checks++; if (rf_we !== 1'b1) $display("FAIL coll_c1_rf_we: got %b want 1", rf_we); else passes++;
        checks++; if (rf_waddr !== 5'd7) $display("FAIL coll_c1_addr: got %0d want 7", rf_waddr); else passes++;
        checks++; if (rf_wdata !== 64'h22) $display("FAIL coll_c1_data: got %h want 22", rf_wdata); else passes++;
        step();
        #2;
        checks++; if (pending_cnt !== 2'd0) $display("FAIL coll_c2_pending: got %0d want 0", pending_cnt); else passes++;
        step();
    endtask

    task automatic test_starvation();
        st_wb_data = '{64'h101, 64'h102, 64'h103, 64'h104, 64'h105, 64'h105};
        st_stall   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        st_addr    = '{5'd1, 5'd1, 5'd1, 5'd1, 5'd9, 5'd1};
        st_data    = '{64'h101, 64'h102, 64'h103, 64'h104, 64'h99, 64'h105};
        lu_valid   = 1'b1;
        lu_rd_addr = 5'd9;
        lu_rd_data = 64'h99;
        #2;
        checks++; if (rf_we !== 1'b0) $display("FAIL starve_c0_rf_we: got %b want 0", rf_we); else passes++;
        step();
        lu_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wb_we      = 1'b1;
            wb_rd_addr = 5'd1;
            wb_rd_data = st_wb_data[i];
            #2;
            checks++; if (stall_req !== st_stall[i]) $display("FAIL starve_c%0d_stall: got %b want %b", i + 1, stall_req, st_stall[i]); else passes++;
            checks++; if (rf_waddr !== st_addr[i]) $display("FAIL starve_c%0d_addr: got %0d want %0d", i + 1, rf_waddr, st_addr[i]); else passes++;
            checks++; if (rf_wdata !== st_data[i]) $display("FAIL starve_c%0d_data: got %h want %h", i + 1, rf_wdata, st_data[i]); else passes++;
            step();
        end
        idle_inputs();
        #2;
        checks++; if (pending_cnt !== 2'd0) $display("FAIL starve_end_pending: got %0d want 0", pending_cnt); else passes++;
        checks++; if (rf_we !== 1'b0) $display("FAIL starve_end_rf_we: got %b want 0", rf_we); else passes++;
        step();
    endtask

    task automatic test_full_and_x0();
        wb_we      = 1'b1;
        wb_rd_addr = 5'd2;
        wb_rd_data = 64'h2000;
        lu_valid   = 1'b1;
        lu_rd_addr = 5'd10;
        lu_rd_data = 64'hA0;
        #2;
        checks++; if (lu_ready !== 1'b1) $display("FAIL full_c0_ready: got %b want 1", lu_ready); else passes++;
        checks++; if (rf_waddr !== 5'd2) $display("FAIL full_c0_addr: got %0d want 2", rf_waddr); else passes++;
        step();
        lu_rd_addr = 5'd11;
        lu_rd_data = 64'hB0;
        #2;
        checks++; if (pending_cnt !== 2'd1) $display("FAIL full_c1_pending: got %0d want 1", pending_cnt); else passes++;
        step();
        lu_rd_addr = 5'd12;
        lu_rd_data = 64'hC0;
        #2;
        checks++; if (lu_ready !== 1'b0) $display("FAIL full_c2_ready: got %b want 0", lu_ready); else passes++;
        checks++; if (pending_cnt !== 2'd2) $display("FAIL full_c2_pending: got %0d want 2", pending_cnt); else passes++;
        checks++; if (rf_waddr !== 5'd2) $display("FAIL full_c2_addr: got %0d want 2", rf_waddr); else passes++;
        step();
        wb_we = 1'b0;
        #2;
        checks++; if (lu_ready !== 1'b0) $display("FAIL full_c3_ready: got %b want 0", lu_ready); else passes++;
        checks++; if (rf_we !== 1'b1) $display("FAIL full_c3_rf_we: got %b want 1", rf_we); else passes++;
        checks++; if (rf_waddr !== 5'd10) $display("FAIL full_c3_addr: got %0d want 10", rf_waddr); else passes++;
        checks++; if (rf_wdata !== 64'hA0) $display("FAIL full_c3_data: got %h want a0", rf_wdata); else passes++;
        step();
        #2;
        checks++; if (lu_ready !== 1'b1) $display("FAIL full_c4_ready: got %b want 1", lu_ready); else passes++;
        checks++; if (rf_waddr !== 5'd11) $display("FAIL full_c4_addr: got %0d want 11", rf_waddr); else passes++;
        checks++; if (rf_wdata !== 64'hB0) $display("FAIL full_c4_data: got %h want b0", rf_wdata); else passes++;
        step();
        lu_rd_addr = 5'd0;
        lu_rd_data = 64'h55;
        #2;
        checks++; if (pending_cnt !== 2'd1) $display("FAIL full_c5_pending: got %0d want 1", pending_cnt); else passes++;
        checks++; if (lu_ready !== 1'b1) $display("FAIL full_c5_ready: got %b want 1", lu_ready); else passes++;
        checks++; if (rf_waddr !== 5'd12) $display("FAIL full_c5_addr: got %0d want 12", rf_waddr); else passes++;
        checks++; if (rf_wdata !== 64'hC0) $display("FAIL full_c5_data: got %h want c0", rf_wdata); else passes++;
        step();
        idle_inputs();
        #2;
        checks++; if (rf_we !== 1'b0) $display("FAIL full_x0_rf_we: got %b want 0", rf_we); else passes++;
        checks++; if (pending_cnt !== 2'd0) $display("FAIL full_x0_pending: got %0d want 0", pending_cnt); else passes++;
        step();
    endtask

    task automatic test_back_to_back();
        wb_we      = 1'b1;
        wb_rd_addr = 5'd0;
        wb_rd_data = 64'hFF;
        lu_valid   = 1'b1;
        lu_rd_addr = 5'd20;
        lu_rd_data = 64'h20;
        #2;
        checks++; if (rf_we !== 1'b0) $display("FAIL b2b_c0_rf_we: got %b want 0", rf_we); else passes++;
        step();
        lu_rd_addr = 5'd21;
        lu_rd_data = 64'h21;
        #2;
        checks++; if (rf_we !== 1'b1) $display("FAIL b2b_c1_rf_we: got %b want 1", rf_we); else passes++;
        checks++; if (rf_waddr !== 5'd20) $display("FAIL b2b_c1_addr: got %0d want 20", rf_waddr); else passes++;
        checks++; if (rf_wdata !== 64'h20) $display("FAIL b2b_c1_data: got %h want 20", rf_wdata); else passes++;
        step();
        idle_inputs();
        #2;
        checks++; if (pending_cnt !== 2'd1) $display("FAIL b2b_c2_pending: got %0d want 1", pending_cnt); else passes++;
        checks++; if (rf_waddr !== 5'd21) $display("FAIL b2b_c2_addr: got %0d want 21", rf_waddr); else passes++;
        checks++; if (rf_wdata !== 64'h21) $display("FAIL b2b_c2_data: got %h want 21", rf_wdata); else passes++;
        step();
        #2;
        checks++; if (pending_cnt !== 2'd0) $display("FAIL b2b_c3_pending: got %0d want 0", pending_cnt); else passes++;
        checks++; if (rf_we !== 1'b0) $display("FAIL b2b_c3_rf_we: got %b want 0", rf_we); else passes++;
        step();
    endtask

    task automatic test_reset_mid_op();
        wb_we      = 1'b1;
        wb_rd_addr = 5'd2;
        wb_rd_data = 64'h2222;
        lu_valid   = 1'b1;
        lu_rd_addr = 5'd13;
        lu_rd_data = 64'h13;
        step();
        lu_rd_addr = 5'd14;
        lu_rd_data = 64'h14;
        step();
        idle_inputs();
        rstn = 1'b0;
        #1;
        checks++; if (pending_cnt !== 2'd0) $display("FAIL rstmid_pending: got %0d want 0", pending_cnt); else passes++;
        checks++; if (rf_we !== 1'b0) $display("FAIL rstmid_rf_we: got %b want 0", rf_we); else passes++;
        checks++; if (lu_ready !== 1'b1) $display("FAIL rstmid_ready: got %b want 1", lu_ready); else passes++;
        #2;
        rstn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            #2;
            checks++; if (rf_we !== 1'b0) $display("FAIL rstmid_after_c%0d: got rf_we %b addr %0d want no write", i, rf_we, rf_waddr); else passes++;
        end
        checks++; if (pending_cnt !== 2'd0) $display("FAIL rstmid_after_pending: got %0d want 0", pending_cnt); else passes++;
        step();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_lone_result();
        test_collision();
        test_starvation();
        test_full_and_x0();
        test_back_to_back();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
